// File: rtl/ahb_slave_if.sv
// AHB-Lite slave front end of the AHB-to-APB bridge: decodes word writes into a
// one-entry hold register feeding the FIFO controller, and answers everything else with ERROR.
module ahb_slave_if #(
  parameter logic [31:0] ADDR_BASE = 32'h8000_0000,
  parameter logic [31:0] ADDR_MASK = 32'hF000_0000
) (
  input  logic        Hclk,
  input  logic        Hresetn,
  input  logic        Hsel,
  input  logic [31:0] Haddr,
  input  logic [1:0]  Htrans,
  input  logic        Hwrite,
  input  logic [2:0]  Hsize,
  input  logic [31:0] Hwdata,
  input  logic        Hready,
  input  logic        full,
  output logic        Hreadyout,
  output logic        Hresp,
  output logic [31:0] Hrdata,
  output logic [31:0] Haddr_temp,
  output logic [31:0] Hwdata_temp,
  output logic        Hwrite_temp,
  output logic        valid
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WDATA = 2'd1,
    ST_ERR1  = 2'd2,
    ST_ERR2  = 2'd3
  } state_t;

  state_t      r_state;
  logic        r_hresp;
  logic [31:0] r_addr_lat;
  logic [31:0] r_hold_addr;
  logic [31:0] r_hold_data;
  logic        r_hold_vld;

  logic        w_accept;
  logic        w_legal;
  logic        w_ready;
  logic        w_load;
  logic        w_valid;
  state_t      w_decode;
  logic        w_unused;

  assign w_unused = Htrans[0];
  assign w_accept = Hsel && Hready && Htrans[1];
  assign w_legal  = Hwrite && (Hsize == 3'b010) && (Haddr[1:0] == 2'b00) &&
                    ((Haddr & ADDR_MASK) == ADDR_BASE);
  assign w_valid  = r_hold_vld && !full;
  assign w_load   = (r_state == ST_WDATA) && w_ready;

  // Slave ready per state; a write data phase only stalls when the hold entry cannot drain.
  always_comb begin
    w_ready = 1'b1;
    case (r_state)
      ST_WDATA: w_ready = !r_hold_vld || !full;
      ST_ERR1:  w_ready = 1'b0;
      default:  w_ready = 1'b1;
    endcase
  end

  // Next state implied by the address phase on the bus this cycle.
  always_comb begin
    w_decode = ST_IDLE;
    if (w_accept) begin
      if (w_legal) begin
        w_decode = ST_WDATA;
      end else begin
        w_decode = ST_ERR1;
      end
    end else begin
      w_decode = ST_IDLE;
    end
  end

  // Bus FSM, address latch and hold register; drain and reload may coincide without a bubble.
  always_ff @(posedge Hclk) begin
    if (!Hresetn) begin
      r_state     <= ST_IDLE;
      r_hresp     <= 1'b0;
      r_addr_lat  <= 32'h0;
      r_hold_addr <= 32'h0;
      r_hold_data <= 32'h0;
      r_hold_vld  <= 1'b0;
    end else begin
      if (w_load) begin
        r_hold_addr <= r_addr_lat;
        r_hold_data <= Hwdata;
        r_hold_vld  <= 1'b1;
      end else if (w_valid) begin
        r_hold_vld  <= 1'b0;
      end

      case (r_state)
        ST_ERR1: begin
          r_state <= ST_ERR2;
          r_hresp <= 1'b1;
        end
        ST_WDATA: begin
          if (w_ready) begin
            r_state <= w_decode;
            r_hresp <= (w_decode == ST_ERR1);
            if (w_decode == ST_WDATA) r_addr_lat <= Haddr;
          end else begin
            r_state <= ST_WDATA;
            r_hresp <= 1'b0;
          end
        end
        default: begin
          r_state <= w_decode;
          r_hresp <= (w_decode == ST_ERR1);
          if (w_decode == ST_WDATA) r_addr_lat <= Haddr;
        end
      endcase
    end
  end

  assign Hreadyout   = w_ready;
  assign Hresp       = r_hresp;
  assign Hrdata      = 32'h0;
  assign Haddr_temp  = r_hold_addr;
  assign Hwdata_temp = r_hold_data;
  assign Hwrite_temp = r_hold_vld;
  assign valid       = w_valid;

endmodule

// File: tb/tb_ahb_slave_if.sv
// Randomized bench for ahb_slave_if: a pipelined AHB master drives transfer lists while a
// transaction-level model predicts responses, hold occupancy and the ordered FIFO write stream.
module tb_ahb_slave_if;

  logic        Hclk = 1'b0;
  logic        Hresetn = 1'b0;
  logic        Hsel = 1'b0;
  logic [31:0] Haddr = 32'h0;
  logic [1:0]  Htrans = 2'b00;
  logic        Hwrite = 1'b0;
  logic [2:0]  Hsize = 3'b000;
  logic [31:0] Hwdata = 32'h0;
  logic        Hready;
  logic        full = 1'b0;
  logic        Hreadyout;
  logic        Hresp;
  logic [31:0] Hrdata;
  logic [31:0] Haddr_temp;
  logic [31:0] Hwdata_temp;
  logic        Hwrite_temp;
  logic        valid;

  assign Hready = Hreadyout;

  ahb_slave_if dut (
    .Hclk(Hclk), .Hresetn(Hresetn), .Hsel(Hsel), .Haddr(Haddr), .Htrans(Htrans),
    .Hwrite(Hwrite), .Hsize(Hsize), .Hwdata(Hwdata), .Hready(Hready), .full(full),
    .Hreadyout(Hreadyout), .Hresp(Hresp), .Hrdata(Hrdata), .Haddr_temp(Haddr_temp),
    .Hwdata_temp(Hwdata_temp), .Hwrite_temp(Hwrite_temp), .valid(valid)
  );

  always #5 Hclk = ~Hclk;

  int n_checks = 0;
  int n_fail   = 0;
  int n_writes = 0;

  // Transfer list consumed by run()
  logic        t_sel   [64];
  logic [1:0]  t_trans [64];
  logic [31:0] t_addr  [64];
  logic        t_write [64];
  logic [2:0]  t_size  [64];
  logic [31:0] t_data  [64];

  // Model state: hold entry present, and the FIFO writes still owed in order
  logic        m_hold = 1'b0;
  logic [63:0] exp_q[$];

  function automatic logic is_legal(input int i);
    return t_write[i] && (t_size[i] == 3'b010) && (t_addr[i][1:0] == 2'b00) &&
           ((t_addr[i] & 32'hF000_0000) == 32'h8000_0000);
  endfunction

  function automatic void set_xfer(input int i, input logic [1:0] tr, input logic [31:0] a,
                                   input logic w, input logic [2:0] sz, input logic [31:0] d);
    t_sel[i] = 1'b1; t_trans[i] = tr; t_addr[i] = a;
    t_write[i] = w;  t_size[i] = sz;  t_data[i] = d;
  endfunction

  task automatic run(input int n, input int full_mode, input int full_hold,
                     input bit wait_drain, input int min_cyc);
    int  ai = 0;
    int  di = 0;
    bit  dp = 1'b0;
    int  err_cnt = 0;
    int  cyc = 0;
    bit  exp_rdy;
    bit  exp_resp;
    bit  exp_valid;
    bit  drained;
    bit  loaded;
    while (!(cyc >= min_cyc && ai >= n && !dp && (!wait_drain || !m_hold))) begin
      if (cyc > 400) begin
        n_checks++; n_fail++;
        $display("FAIL timeout: run did not complete, ai=%0d dp=%0d hold=%0d", ai, dp, m_hold);
        break;
      end
      case (full_mode)
        0:       full = 1'b0;
        1:       full = ($urandom_range(0, 3) == 0);
        default: full = (cyc < full_hold);
      endcase
      if (ai < n) begin
        Hsel = t_sel[ai]; Htrans = t_trans[ai]; Haddr = t_addr[ai];
        Hwrite = t_write[ai]; Hsize = t_size[ai];
      end else begin
        Hsel = $urandom_range(0, 1); Htrans = 2'b00; Haddr = $urandom;
        Hwrite = $urandom_range(0, 1); Hsize = 3'b010;
      end
      Hwdata = dp ? t_data[di] : $urandom;
      #4;
      exp_valid = m_hold && !full;
      if (dp && is_legal(di)) begin
        exp_rdy = !m_hold || !full; exp_resp = 1'b0;
      end else if (dp) begin
        exp_rdy = (err_cnt == 1); exp_resp = 1'b1;
      end else begin
        exp_rdy = 1'b1; exp_resp = 1'b0;
      end
      n_checks++;
      if (Hreadyout !== exp_rdy) begin
        n_fail++; $display("FAIL hreadyout: cyc=%0d got %b exp %b", cyc, Hreadyout, exp_rdy);
      end
      n_checks++;
      if (Hresp !== exp_resp) begin
        n_fail++; $display("FAIL hresp: cyc=%0d got %b exp %b", cyc, Hresp, exp_resp);
      end
      n_checks++;
      if (valid !== exp_valid) begin
        n_fail++; $display("FAIL valid: cyc=%0d got %b exp %b", cyc, valid, exp_valid);
      end
      n_checks++;
      if (Hwrite_temp !== m_hold) begin
        n_fail++; $display("FAIL hwrite_temp: cyc=%0d got %b exp %b", cyc, Hwrite_temp, m_hold);
      end
      n_checks++;
      if (Hrdata !== 32'h0) begin
        n_fail++; $display("FAIL hrdata: got %h exp 00000000", Hrdata);
      end
      if (exp_valid && exp_q.size() > 0) begin
        n_checks++;
        if ({Haddr_temp, Hwdata_temp} !== exp_q[0]) begin
          n_fail++;
          $display("FAIL fifo_entry: got addr %h data %h exp addr %h data %h",
                   Haddr_temp, Hwdata_temp, exp_q[0][63:32], exp_q[0][31:0]);
        end
      end
      // Advance the model and the master on the bus handshake at the coming edge
      drained = m_hold && !full;
      loaded  = dp && is_legal(di) && Hreadyout;
      if (drained && exp_q.size() > 0) begin
        void'(exp_q.pop_front());
        n_writes++;
      end
      if (loaded) exp_q.push_back({t_addr[di], t_data[di]});
      m_hold = loaded ? 1'b1 : (drained ? 1'b0 : m_hold);
      if (Hreadyout) begin
        dp = 1'b0;
        err_cnt = 0;
        if (ai < n) begin
          dp = t_sel[ai] && t_trans[ai][1];
          di = ai;
          ai++;
        end
      end else if (dp && !is_legal(di)) begin
        err_cnt++;
      end
      @(posedge Hclk); #1;
      cyc++;
    end
    if (wait_drain) begin
      n_checks++;
      if (exp_q.size() != 0) begin
        n_fail++; $display("FAIL drain: %0d entries never written, exp 0", exp_q.size());
      end
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    n_checks++;
    if ({Hreadyout, Hresp, valid, Hwrite_temp} !== 4'b1000 ||
        Haddr_temp !== 32'h0 || Hwdata_temp !== 32'h0) begin
      n_fail++;
      $display("FAIL %s: got rdy=%b resp=%b valid=%b wt=%b at=%h wd=%h exp 1 0 0 0 0 0",
               tag, Hreadyout, Hresp, valid, Hwrite_temp, Haddr_temp, Hwdata_temp);
    end
  endtask

  task automatic apply_reset();
    Hresetn = 1'b0;
    for (int i = 0; i < 2; i++) begin
      Hsel = $urandom_range(0, 1); Htrans = $urandom_range(0, 3); Haddr = $urandom;
      Hwrite = $urandom_range(0, 1); Hsize = $urandom_range(0, 7); Hwdata = $urandom;
      full = $urandom_range(0, 1);
      @(posedge Hclk); #1;
    end
    #4;
    m_hold = 1'b0;
    exp_q.delete();
  endtask

  task automatic test_reset();
    @(posedge Hclk); #1;
    apply_reset();
    check_idle_outputs("reset");
    Hresetn = 1'b1;
    Htrans = 2'b00;
    full = 1'b0;
    @(posedge Hclk); #1;
  endtask

  task automatic test_single_write();
    set_xfer(0, 2'b10, 32'h8000_0010, 1'b1, 3'b010, 32'hDEAD_BEEF);
    run(1, 0, 0, 1'b1, 3);
  endtask

  task automatic test_burst();
    for (int i = 0; i < 4; i++)
      set_xfer(i, (i == 0) ? 2'b10 : 2'b11, 32'h8000_0000 + 32'(4 * i), 1'b1, 3'b010, $urandom);
    run(4, 0, 0, 1'b1, 2);
  endtask

  task automatic test_full_stall();
    set_xfer(0, 2'b10, 32'h8000_0100, 1'b1, 3'b010, 32'h1111_1111);
    set_xfer(1, 2'b11, 32'h8000_0104, 1'b1, 3'b010, 32'h2222_2222);
    run(2, 2, 7, 1'b1, 2);
  endtask

  task automatic test_errors();
    set_xfer(0, 2'b10, 32'h8000_0000, 1'b0, 3'b010, $urandom);
    set_xfer(1, 2'b10, 32'h1000_0000, 1'b1, 3'b010, $urandom);
    set_xfer(2, 2'b10, 32'h8000_0000, 1'b1, 3'b000, $urandom);
    set_xfer(3, 2'b10, 32'h8000_0002, 1'b1, 3'b010, $urandom);
    set_xfer(4, 2'b10, 32'h8000_0040, 1'b1, 3'b010, 32'h5A5A_A5A5);
    run(5, 0, 0, 1'b1, 2);
  endtask

  task automatic test_random();
    for (int i = 0; i < 48; i++) begin
      int k;
      logic [31:0] a;
      k = $urandom_range(0, 11);
      a = 32'h8000_0000 | ($urandom & 32'h0FFF_FFFC);
      set_xfer(i, $urandom_range(0, 1) ? 2'b11 : 2'b10, a, 1'b1, 3'b010, $urandom);
      case (k)
        0:       t_write[i] = 1'b0;
        1:       t_addr[i]  = {4'($urandom_range(0, 7)), a[27:0]};
        2:       t_size[i]  = 3'($urandom_range(0, 1));
        3:       t_addr[i]  = a | 32'($urandom_range(1, 3));
        4:       t_trans[i] = 2'($urandom_range(0, 1));
        5:       t_sel[i]   = 1'b0;
        default: ;
      endcase
    end
    run(48, 1, 0, 1'b1, 2);
  endtask

  task automatic test_reset_pending();
    int w0;
    set_xfer(0, 2'b10, 32'h8000_0200, 1'b1, 3'b010, 32'hCAFE_F00D);
    run(1, 2, 1000, 1'b0, 3);
    w0 = n_writes;
    apply_reset();
    check_idle_outputs("reset_pending");
    Hresetn = 1'b1;
    run(0, 0, 0, 1'b1, 6);
    n_checks++;
    if (n_writes != w0) begin
      n_fail++; $display("FAIL reset_discard: %0d writes after reset, exp 0", n_writes - w0);
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_burst();
    test_full_stall();
    test_errors();
    test_random();
    test_reset_pending();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
